// File: rtl/clk_en_sequencer.sv
// Power-up sequencer: waits for PLL lock, stabilises, releases PPU then CPU reset,
// and generates master/4 and master/12 clock enables. Optional macro NES_STEP_EN adds CPU halt/single-step.
module clk_en_sequencer #(
    parameter int unsigned STAB_CYCLES = 1024,
    parameter int unsigned GAP_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
`ifdef NES_STEP_EN
    input  logic       cpu_halt,
    input  logic       cpu_step,
`endif
    output logic       ppu_rst,
    output logic       cpu_rst,
    output logic       ppu_ce,
    output logic       cpu_ce,
    output logic       ready,
    output logic       lock_lost,
    output logic [1:0] dbg_state,
    output logic [3:0] dbg_phase
);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_STAB   = 2'd1,
        S_PPU_UP = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam logic [15:0] STAB_LAST = 16'(STAB_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] stab_cnt;
    logic [15:0] stab_cnt_next;
    logic [7:0]  gap_cnt;
    logic [7:0]  gap_cnt_next;
    logic [3:0]  phase;
    logic [3:0]  phase_next;
    logic        lock_drop;

    logic        ppu_rst_next;
    logic        cpu_rst_next;
    logic        ppu_ce_next;
    logic        cpu_ce_next;
    logic        ready_next;
    logic        ce_phase;
    logic        cpu_slot;
    logic        cpu_gate;

    assign ce_phase = (phase == 4'd3) || (phase == 4'd7) || (phase == 4'd11);
    assign cpu_slot = (phase == 4'd11);

    // Phase 0 is the first cycle the PPU sees ppu_rst low, so the phase
    // counter holds until the registered reset output has actually dropped.
    always_comb begin
        state_next    = state;
        stab_cnt_next = stab_cnt;
        gap_cnt_next  = gap_cnt;
        phase_next    = phase;
        lock_drop     = 1'b0;

        case (state)
            S_WAIT: begin
                stab_cnt_next = 16'd0;
                gap_cnt_next  = 8'd0;
                phase_next    = 4'd0;
                if (pll_locked) begin
                    state_next = S_STAB;
                end
            end
            S_STAB: begin
                if (stab_cnt == STAB_LAST) begin
                    state_next    = S_PPU_UP;
                    stab_cnt_next = 16'd0;
                end else begin
                    stab_cnt_next = stab_cnt + 16'd1;
                end
            end
            S_PPU_UP: begin
                if (!ppu_rst) begin
                    phase_next = cpu_slot ? 4'd0 : phase + 4'd1;
                end
                if (gap_cnt == GAP_LAST) begin
                    state_next   = S_RUN;
                    gap_cnt_next = 8'd0;
                end else begin
                    gap_cnt_next = gap_cnt + 8'd1;
                end
            end
            S_RUN: begin
                phase_next = cpu_slot ? 4'd0 : phase + 4'd1;
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase

        if (state != S_WAIT && !pll_locked) begin
            lock_drop     = 1'b1;
            state_next    = S_WAIT;
            stab_cnt_next = 16'd0;
            gap_cnt_next  = 8'd0;
            phase_next    = 4'd0;
        end
    end

`ifdef NES_STEP_EN
    logic step_pend;
    logic step_pend_next;
    logic step_take;

    // A pending step is consumed by the first phase-11 RUN slot while halted.
    always_comb begin
        cpu_gate       = !cpu_halt || step_pend;
        step_take      = (state == S_RUN) && cpu_slot && cpu_halt && step_pend && !lock_drop;
        step_pend_next = cpu_step || (step_pend && !step_take);
        if (state == S_WAIT || lock_drop) begin
            step_pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_pend <= 1'b0;
        end else begin
            step_pend <= step_pend_next;
        end
    end
`else
    assign cpu_gate = 1'b1;
`endif

    // Outputs follow the current state one edge later, except that a lock
    // drop forces the reset pattern on the very edge that enters WAIT.
    always_comb begin
        ppu_rst_next = 1'b1;
        cpu_rst_next = 1'b1;
        ppu_ce_next  = 1'b0;
        cpu_ce_next  = 1'b0;
        ready_next   = 1'b0;
        if (!lock_drop) begin
            case (state)
                S_PPU_UP: begin
                    ppu_rst_next = 1'b0;
                    ppu_ce_next  = ce_phase;
                end
                S_RUN: begin
                    ppu_rst_next = 1'b0;
                    cpu_rst_next = 1'b0;
                    ready_next   = 1'b1;
                    ppu_ce_next  = ce_phase;
                    cpu_ce_next  = cpu_slot && cpu_gate;
                end
                default: begin
                    ppu_rst_next = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT;
            stab_cnt  <= 16'd0;
            gap_cnt   <= 8'd0;
            phase     <= 4'd0;
            ppu_rst   <= 1'b1;
            cpu_rst   <= 1'b1;
            ppu_ce    <= 1'b0;
            cpu_ce    <= 1'b0;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_next;
            stab_cnt  <= stab_cnt_next;
            gap_cnt   <= gap_cnt_next;
            phase     <= phase_next;
            ppu_rst   <= ppu_rst_next;
            cpu_rst   <= cpu_rst_next;
            ppu_ce    <= ppu_ce_next;
            cpu_ce    <= cpu_ce_next;
            ready     <= ready_next;
            lock_lost <= lock_lost || lock_drop;
        end
    end

    assign dbg_state = state;
    assign dbg_phase = phase;

endmodule

// File: tb/tb_clk_en_sequencer.sv
// Directed bench for clk_en_sequencer with STAB_CYCLES=8, GAP_CYCLES=4.
// Edge e=0 is the first edge that samples pll_locked=1 after WAIT.
module tb_clk_en_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       ppu_rst;
    logic       cpu_rst;
    logic       ppu_ce;
    logic       cpu_ce;
    logic       ready;
    logic       lock_lost;
    logic [1:0] dbg_state;
    logic [3:0] dbg_phase;
`ifdef NES_STEP_EN
    logic       cpu_halt;
    logic       cpu_step;
`endif

    int         checks = 0;
    int         errors = 0;
    logic       exp_ll = 1'b0;
    bit         halted = 1'b0;
    int         step_ce_edge = -1;
    bit         sb_on = 1'b0;
    int         cpu_ce_cnt = 0;
    logic [31:0] exp_q[$];

    clk_en_sequencer #(
        .STAB_CYCLES(8),
        .GAP_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_locked(pll_locked),
`ifdef NES_STEP_EN
        .cpu_halt  (cpu_halt),
        .cpu_step  (cpu_step),
`endif
        .ppu_rst   (ppu_rst),
        .cpu_rst   (cpu_rst),
        .ppu_ce    (ppu_ce),
        .cpu_ce    (cpu_ce),
        .ready     (ready),
        .lock_lost (lock_lost),
        .dbg_state (dbg_state),
        .dbg_phase (dbg_phase)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag, input logic ll);
        chk({tag, " ppu_rst"}, 32'(ppu_rst), 32'd1);
        chk({tag, " cpu_rst"}, 32'(cpu_rst), 32'd1);
        chk({tag, " ppu_ce"}, 32'(ppu_ce), 32'd0);
        chk({tag, " cpu_ce"}, 32'(cpu_ce), 32'd0);
        chk({tag, " ready"}, 32'(ready), 32'd0);
        chk({tag, " lock_lost"}, 32'(lock_lost), 32'(ll));
        chk({tag, " state"}, 32'(dbg_state), 32'd0);
        chk({tag, " phase"}, 32'(dbg_phase), 32'd0);
    endtask

    // Hand-derived timeline for 8+4: ppu_rst low from 9, cpu_rst low/ready from 13,
    // ppu_ce at 13,17,21..., cpu_ce at 21,33,..., PPU_UP entered at 8, RUN at 12.
    task automatic check_edge(input int e);
        logic       e_ppu_rst, e_cpu_rst, e_ppu_ce, e_cpu_ce;
        logic [1:0] e_state;
        logic [3:0] e_phase;
        string      t;
        e_ppu_rst = (e < 9);
        e_cpu_rst = (e < 13);
        e_ppu_ce  = (e >= 13) && ((e - 13) % 4 == 0);
        e_cpu_ce  = halted ? (e == step_ce_edge) : ((e >= 21) && ((e - 21) % 12 == 0));
        e_state   = (e < 8) ? 2'd1 : (e < 12) ? 2'd2 : 2'd3;
        e_phase   = (e <= 9) ? 4'd0 : 4'((e - 9) % 12);
        t = $sformatf("e%0d", e);
        chk({t, " ppu_rst"}, 32'(ppu_rst), 32'(e_ppu_rst));
        chk({t, " cpu_rst"}, 32'(cpu_rst), 32'(e_cpu_rst));
        chk({t, " ready"}, 32'(ready), 32'(!e_cpu_rst));
        chk({t, " ppu_ce"}, 32'(ppu_ce), 32'(e_ppu_ce));
        chk({t, " cpu_ce"}, 32'(cpu_ce), 32'(e_cpu_ce));
        chk({t, " lock_lost"}, 32'(lock_lost), 32'(exp_ll));
        chk({t, " state"}, 32'(dbg_state), 32'(e_state));
        chk({t, " phase"}, 32'(dbg_phase), 32'(e_phase));
        // scoreboard: cpu_ce pulses in the 120-cycle steady window
        if (sb_on && e >= 14 && e <= 133 && cpu_ce === 1'b1) begin
            cpu_ce_cnt++;
            if (exp_q.size() == 0) begin
                chk({t, " sb_extra_cpu_ce"}, 32'(e), 32'hFFFF_FFFF);
            end else begin
                chk({t, " sb_cpu_ce_edge"}, 32'(e), exp_q.pop_front());
            end
        end
    endtask

    task automatic run_seq(input int first, input int last);
        for (int e = first; e <= last; e++) begin
            tick();
            check_edge(e);
        end
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
`ifdef NES_STEP_EN
        cpu_halt   = 1'b0;
        cpu_step   = 1'b0;
`endif
        repeat (3) tick();
        check_reset("por", 1'b0);

        // Power-up with lock held, then 120 steady RUN cycles
        rst        = 1'b0;
        pll_locked = 1'b1;
        for (int k = 0; k < 10; k++) exp_q.push_back(32'(21 + 12 * k));
        sb_on = 1'b1;
        run_seq(0, 140);
        sb_on = 1'b0;
        chk("sb_queue_left", 32'(exp_q.size()), 32'd0);
        chk("cpu_ce_count", 32'(cpu_ce_cnt), 32'd10);

        // One-cycle lock glitch mid-RUN, on a cycle where both enables were due
        pll_locked = 1'b0;
        tick();
        exp_ll = 1'b1;
        check_reset("drop_run", 1'b1);
        pll_locked = 1'b1;
        run_seq(0, 25);

        pll_locked = 1'b0;
        tick();
        check_reset("drop_run2", 1'b1);
        tick();
        check_reset("wait_idle", 1'b1);

        // Lock drops at STAB count 5; relock restarts from 0
        pll_locked = 1'b1;
        run_seq(0, 5);
        pll_locked = 1'b0;
        tick();
        check_reset("drop_stab", 1'b1);
        pll_locked = 1'b1;
        run_seq(0, 13);

        // rst mid-RUN clears lock_lost, rst dominates pll_locked
        rst = 1'b1;
        tick();
        check_reset("rst_run", 1'b0);
        tick();
        check_reset("rst_hold", 1'b0);
        exp_ll = 1'b0;
        rst = 1'b0;
        run_seq(0, 10);
        rst = 1'b1;
        tick();
        check_reset("rst_ppu_up", 1'b0);
        rst = 1'b0;

`ifdef NES_STEP_EN
        // Halted: three steps in one window yield one cpu_ce at edge 57
        halted   = 1'b1;
        cpu_halt = 1'b1;
        run_seq(0, 45);
        step_ce_edge = 57;
        for (int e = 46; e <= 90; e++) begin
            cpu_step = (e == 46) || (e == 48) || (e == 50);
            tick();
            check_edge(e);
        end
        cpu_step = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
